wb_arbiter: RTL and testbench

Writeback arbiter driving the single write port of the integer register file. It merges results from the ALU pipe and from the load/store unit (LSU), whose load data returns with variable latency. LSU results are buffered in a small FIFO. Writes are then presented to the register file one per cycle on registered `o_rd_addr` / `o_rd_data` / `o_write_en` outputs.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the integer writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // Source of the result currently being written back
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  // One writeback result at the default data width
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_result_t;

  // x0 is hardwired to zero, so results aimed at it are consumed but never written
  function automatic logic wb_is_write(input logic [REG_ADDR_W-1:0] rd);
    return (rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO buffering LSU writeback results.
//               Pointers carry an extra wrap bit to tell full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags and gated push/pop: a full FIFO never accepts, an empty one never pops
  always_comb begin
    o_empty  = (wr_ptr_q == rd_ptr_q);
    o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    o_head   = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the FIFO regardless of storage contents
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Merges ALU and buffered LSU results onto the single register
//               file write port, one registered write per cycle. LSU head
//               entries that wait STARVE_LIMIT cycles preempt the ALU.
//               Optional macro WB_TRACE_EN prints every writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_alu_valid,
  output logic                          o_alu_ready,
  input  logic [wb_pkg::REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]               i_alu_data,
  input  logic                          i_lsu_valid,
  output logic                          o_lsu_ready,
  input  logic [wb_pkg::REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]               i_lsu_data,
  output logic [wb_pkg::REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]               o_rd_data,
  output logic                          o_write_en
);

  import wb_pkg::*;

  localparam int ENT_W = REG_ADDR_W + XLEN;
  localparam int AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENT_W-1:0]      fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  lsu_push;
  logic                  lsu_grant;

  logic [AGE_W-1:0]      age_q, age_d;
  logic                  write_en_q, write_en_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;

  wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LSU_DEPTH)
  ) u_lsu_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (lsu_push),
    .i_wdata ({i_lsu_rd, i_lsu_data}),
    .i_pop   (lsu_grant),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_head  (fifo_head)
  );

  // Arbitration, next write-port values and head age update
  always_comb begin
    head_rd     = fifo_head[XLEN +: REG_ADDR_W];
    head_data   = fifo_head[XLEN-1:0];
    o_lsu_ready = !fifo_full;
    lsu_push    = i_lsu_valid && !fifo_full;
    lsu_grant   = !fifo_empty && ((age_q >= AGE_LIMIT) || fifo_full || !i_alu_valid);
    o_alu_ready = !lsu_grant;

    write_en_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    if (lsu_grant) begin
      if (wb_is_write(head_rd)) begin
        write_en_d = 1'b1;
        rd_addr_d  = head_rd;
        rd_data_d  = head_data;
      end
    end else if (i_alu_valid) begin
      if (wb_is_write(i_alu_rd)) begin
        write_en_d = 1'b1;
        rd_addr_d  = i_alu_rd;
        rd_data_d  = i_alu_data;
      end
    end

    if (lsu_grant || fifo_empty) begin
      age_d = '0;
    end else if (age_q < AGE_LIMIT) begin
      age_d = age_q + AGE_W'(1);
    end else begin
      age_d = age_q;
    end
  end

  // Registered write port and age counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      age_q      <= '0;
      write_en_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      age_q      <= age_d;
      write_en_q <= write_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_write_en = write_en_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rd_data  = rd_data_q;

`ifdef WB_TRACE_EN
  wb_src_e               trace_src_q, trace_src_d;
  logic                  trace_drop_q, trace_drop_d;

  // Remember where the registered result came from and whether it was dropped
  always_comb begin
    trace_src_d  = lsu_grant ? WB_SRC_LSU : WB_SRC_ALU;
    trace_drop_d = lsu_grant || i_alu_valid ? !write_en_d : 1'b0;
  end

  // Trace source registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trace_src_q  <= WB_SRC_ALU;
      trace_drop_q <= 1'b0;
    end else begin
      trace_src_q  <= trace_src_d;
      trace_drop_q <= trace_drop_d;
    end
  end

  // Print each writeback and each discarded x0 result
  always @(posedge i_clk) begin
    if (i_rst_n && o_write_en) begin
      $display("wb: src=%s rd=%0d data=%h",
               (trace_src_q == WB_SRC_LSU) ? "LSU" : "ALU", o_rd_addr, o_rd_data);
    end
    if (i_rst_n && trace_drop_q) begin
      $display("wb: src=%s rd=0 discarded",
               (trace_src_q == WB_SRC_LSU) ? "LSU" : "ALU");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. A queue-based reference
//               model tracks buffered loads, head age and the expected write
//               port; directed scenarios add their own spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_alu_valid;
  logic            o_alu_ready;
  logic [4:0]      i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic [4:0]      i_lsu_rd;
  logic [XLEN-1:0] i_lsu_data;
  logic [4:0]      o_rd_addr;
  logic [XLEN-1:0] o_rd_data;
  logic            o_write_en;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t            m_q[$];
  int              m_age;
  logic            m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;

  wb_arbiter #(
    .XLEN         (XLEN),
    .LSU_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_alu_valid (i_alu_valid),
    .o_alu_ready (o_alu_ready),
    .i_alu_rd    (i_alu_rd),
    .i_alu_data  (i_alu_data),
    .i_lsu_valid (i_lsu_valid),
    .o_lsu_ready (o_lsu_ready),
    .i_lsu_rd    (i_lsu_rd),
    .i_lsu_data  (i_lsu_data),
    .o_rd_addr   (o_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_write_en  (o_write_en)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_q.delete();
    m_age  = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare every
  // output against the model, then advance the model across the next edge.
  task automatic step(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                      output bit alu_acc, output bit lsu_acc);
    int   sz;
    bit   exp_lrdy, g_lsu, exp_ardy;
    ent_t e;
    @(negedge i_clk);
    i_alu_valid = av; i_alu_rd = ard; i_alu_data = ad;
    i_lsu_valid = lv; i_lsu_rd = lrd; i_lsu_data = ld;
    #1;
    sz       = m_q.size();
    exp_lrdy = (sz < DEPTH);
    g_lsu    = (sz > 0) && (m_age >= LIMIT || sz == DEPTH || !av);
    exp_ardy = !g_lsu;
    total++;
    if (o_alu_ready !== exp_ardy) begin
      bad++; $display("FAIL alu_ready got=%b exp=%b t=%0t", o_alu_ready, exp_ardy, $time);
    end
    total++;
    if (o_lsu_ready !== exp_lrdy) begin
      bad++; $display("FAIL lsu_ready got=%b exp=%b t=%0t", o_lsu_ready, exp_lrdy, $time);
    end
    total++;
    if (o_write_en !== m_we) begin
      bad++; $display("FAIL write_en got=%b exp=%b t=%0t", o_write_en, m_we, $time);
    end
    total++;
    if (o_rd_addr !== m_addr) begin
      bad++; $display("FAIL rd_addr got=%0d exp=%0d t=%0t", o_rd_addr, m_addr, $time);
    end
    total++;
    if (o_rd_data !== m_data) begin
      bad++; $display("FAIL rd_data got=%h exp=%h t=%0t", o_rd_data, m_data, $time);
    end
    // Advance the model across the coming rising edge
    m_we = 1'b0;
    if (g_lsu) begin
      e = m_q.pop_front();
      if (e.rd != 0) begin m_we = 1'b1; m_addr = e.rd; m_data = e.data; end
    end else if (av) begin
      if (ard != 0) begin m_we = 1'b1; m_addr = ard; m_data = ad; end
    end
    if (g_lsu || sz == 0) m_age = 0;
    else if (m_age < LIMIT) m_age = m_age + 1;
    if (lv && exp_lrdy) m_q.push_back('{rd: lrd, data: ld});
    alu_acc = av && !g_lsu;
    lsu_acc = lv && exp_lrdy;
  endtask

  task automatic idle(input int n);
    bit a, l;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a, l);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
    i_lsu_valid = 0; i_lsu_rd = 0; i_lsu_data = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    total++;
    if (o_write_en !== 1'b0 || o_rd_addr !== 5'd0 || o_rd_data !== '0) begin
      bad++; $display("FAIL reset_outputs got we=%b addr=%0d data=%h exp 0/0/0",
                      o_write_en, o_rd_addr, o_rd_data);
    end
    total++;
    if (o_lsu_ready !== 1'b1 || o_alu_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got lsu=%b alu=%b exp 1/1", o_lsu_ready, o_alu_ready);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_alu_basic();
    bit a, l;
    idle(1);
    step(1, 5, 32'h11, 0, 0, 0, a, l);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL alu_basic_accept got=%b exp=1", a); end
    idle(1);
    total++;
    if (o_write_en !== 1'b1 || o_rd_addr !== 5'd5 || o_rd_data !== 32'h11) begin
      bad++; $display("FAIL alu_basic_write got we=%b addr=%0d data=%h exp 1/5/11",
                      o_write_en, o_rd_addr, o_rd_data);
    end
  endtask

  task automatic test_lsu_basic();
    bit a, l;
    step(0, 0, 0, 1, 7, 32'hAA, a, l);
    idle(1);
    total++;
    if (o_write_en !== 1'b0) begin bad++; $display("FAIL lsu_basic_early got we=%b exp=0", o_write_en); end
    idle(1);
    total++;
    if (o_write_en !== 1'b1 || o_rd_addr !== 5'd7 || o_rd_data !== 32'hAA) begin
      bad++; $display("FAIL lsu_basic_write got we=%b addr=%0d data=%h exp 1/7/aa",
                      o_write_en, o_rd_addr, o_rd_data);
    end
    total++;
    if (m_q.size() != 0 || o_lsu_ready !== 1'b1) begin
      bad++; $display("FAIL lsu_basic_drain got lsu_ready=%b exp=1", o_lsu_ready);
    end
  endtask

  task automatic test_starve();
    bit acc[7];
    bit l;
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
    idle(2);
    rd = 5'd1 + 5'($urandom_range(0, 29)); d = $urandom;
    for (int i = 0; i < 7; i++) begin
      step(1, rd, d, i == 0, 9, 32'hBEEF, acc[i], l);
      if (acc[i]) begin rd = 5'd1 + 5'($urandom_range(0, 29)); d = $urandom; end
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (acc[i] !== (i != 5)) begin
        bad++; $display("FAIL starve_alu_ready cycle=%0d got=%b exp=%b", i, acc[i], i != 5);
      end
    end
    total++;
    if (o_write_en !== 1'b1 || o_rd_addr !== 5'd9 || o_rd_data !== 32'hBEEF) begin
      bad++; $display("FAIL starve_write got we=%b addr=%0d data=%h exp 1/9/beef",
                      o_write_en, o_rd_addr, o_rd_data);
    end
    idle(2);
  endtask

  task automatic test_full();
    bit a, l;
    step(1, 3, 32'h30, 1, 20, 32'hA0, a, l);
    step(1, 3, 32'h30, 1, 21, 32'hA1, a, l);
    step(1, 4, 32'h40, 0, 0, 0, a, l);
    total++;
    if (o_lsu_ready !== 1'b0 || a !== 1'b0) begin
      bad++; $display("FAIL full_grant got lsu_ready=%b alu_acc=%b exp 0/0", o_lsu_ready, a);
    end
    step(1, 4, 32'h40, 0, 0, 0, a, l);
    total++;
    if (o_lsu_ready !== 1'b1 || o_write_en !== 1'b1 || o_rd_addr !== 5'd20) begin
      bad++; $display("FAIL full_release got lsu_ready=%b we=%b addr=%0d exp 1/1/20",
                      o_lsu_ready, o_write_en, o_rd_addr);
    end
    idle(4);
  endtask

  task automatic test_rd_zero();
    bit a, l;
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, a, l);
    total++;
    if (o_alu_ready !== 1'b1) begin bad++; $display("FAIL rd0_accept got=%b exp=1", o_alu_ready); end
    idle(1);
    total++;
    if (o_write_en !== 1'b0) begin bad++; $display("FAIL rd0_write got we=%b exp=0", o_write_en); end
  endtask

  task automatic test_back_to_back();
    bit a, l;
    for (int i = 0; i < 8; i++) begin
      step(1, 5'd1 + 5'(i), $urandom, 0, 0, 0, a, l);
      if (i > 0) begin
        total++;
        if (o_write_en !== 1'b1 || o_rd_addr !== 5'(i)) begin
          bad++; $display("FAIL b2b_write cycle=%0d got we=%b addr=%0d exp 1/%0d",
                          i, o_write_en, o_rd_addr, i);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_random();
    bit              pend, a, l;
    logic [4:0]      ard;
    logic [XLEN-1:0] ad;
    pend = 0; ard = 0; ad = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend = 1; ard = 5'($urandom); ad = $urandom;
      end
      step(pend, ard, ad, $urandom_range(0, 9) < 4, 5'($urandom), $urandom, a, l);
      if (a) pend = 0;
    end
    idle(6);
  endtask

  task automatic test_reset_mid();
    bit a, l;
    step(1, 12, 32'h1234, 1, 3, 32'h5555, a, l);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (o_write_en !== 1'b0 || o_rd_addr !== 5'd0 || o_rd_data !== '0) begin
      bad++; $display("FAIL mid_reset_outputs got we=%b addr=%0d data=%h exp 0/0/0",
                      o_write_en, o_rd_addr, o_rd_data);
    end
    total++;
    if (o_lsu_ready !== 1'b1 || o_alu_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset_ready got lsu=%b alu=%b exp 1/1", o_lsu_ready, o_alu_ready);
    end
    i_alu_valid = 0; i_lsu_valid = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_lsu_basic();
    test_starve();
    test_full();
    test_rd_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
